// File: rtl/fifo_rd_unpack.sv
// fifo_rd_unpack: drains a 16-bit FIFO in bursts once it reaches a threshold and streams each word out as two bytes
module fifo_rd_unpack #(
  parameter int IN_W      = 16,
  parameter int OUT_W     = 8,
  parameter int USEDW_W   = 8,
  parameter int START_TH  = 128,
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic               sys_clk,
  input  logic               sys_rst_n,
  input  logic [IN_W-1:0]    fifo_rd_data,
  input  logic               fifo_rd_empty,
  input  logic               fifo_rd_full,
  input  logic [USEDW_W-1:0] fifo_rd_usedw,
  output logic               fifo_rd_req,
  output logic [OUT_W-1:0]   byte_data,
  output logic               byte_valid,
  input  logic               byte_ready,
  output logic               busy,
  output logic               burst_done,
  output logic [USEDW_W:0]   word_cnt
);
  typedef enum logic [2:0] {IDLE, REQ, LATCH, SEND0, SEND1} state_t;
  localparam logic [USEDW_W:0] TH = START_TH[USEDW_W:0];
  state_t state;
  logic [OUT_W-1:0] hold;
  logic [OUT_W-1:0] first_in, second_in;
  assign first_in    = LSB_FIRST ? fifo_rd_data[OUT_W-1:0] : fifo_rd_data[IN_W-1:OUT_W];
  assign second_in   = LSB_FIRST ? fifo_rd_data[IN_W-1:OUT_W] : fifo_rd_data[OUT_W-1:0];
  assign fifo_rd_req = (state == REQ) && !fifo_rd_empty;
  assign busy        = state != IDLE;
  // full covers the usedw wrap to 0 when the FIFO holds its maximum
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state      <= IDLE;
      byte_valid <= 1'b0;
      byte_data  <= '0;
      hold       <= '0;
      burst_done <= 1'b0;
      word_cnt   <= '0;
    end else begin
      burst_done <= 1'b0;
      case (state)
        IDLE: if (fifo_rd_full || {1'b0, fifo_rd_usedw} >= TH) begin
          state    <= REQ;
          word_cnt <= '0;
        end
        REQ: if (!fifo_rd_empty) begin
          state    <= LATCH;
          word_cnt <= word_cnt + {{USEDW_W{1'b0}}, ~&word_cnt};
        end else begin
          state      <= IDLE;
          burst_done <= 1'b1;
        end
        LATCH: begin
          byte_data  <= first_in;
          hold       <= second_in;
          byte_valid <= 1'b1;
          state      <= SEND0;
        end
        SEND0: if (byte_ready) begin
          byte_data <= hold;
          state     <= SEND1;
        end
        SEND1: if (byte_ready) begin
          byte_valid <= 1'b0;
          state      <= REQ;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
